decoder_sweep: RTL and testbench
================================

# decoder_sweep

Parametrised, registered line decoder with an autonomous sweep mode; the clocked successor of the fixed 2x4/3x8/4x16/5x32 line decoders. In direct mode it registers a one-hot decode of a binary index each cycle. In sweep mode it walks the one-hot output across every line, holding each line for a programmable number of cycles, and signals completion. It is used as the write-select and clear sequencer in front of the register file.

## Interface
- ADDR_W, 5: index width; output width OUT_W = 2**ADDR_W (local, derived).
- DWELL, 1: cycles each line is held during a sweep; legal range 1..255.
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- EN  input  1  direct-mode decode enable.
- I  input  ADDR_W  direct-mode index.
- START  input  1  sweep request, sampled in IDLE only.
- ABORT  input  1  terminates an active sweep.
- D  output  OUT_W  registered one-hot (or all-zero) decode.
- IDX  output  ADDR_W  index currently driven on D.
- VALID  output  1  D holds a one-hot value.
- BUSY  output  1  sweep in progress.
- DONE  output  1  one-cycle pulse at sweep completion.
- One clock, CLK. Reset RST is asynchronous and active-high.

## Operation
- All outputs are registered. On RST: state = IDLE, D = 0, IDX = 0, VALID = 0, BUSY = 0, DONE = 0, dwell counter = 0.
- IDLE:
  - START = 1 → go to SWEEP. D = 1, IDX = 0, VALID = 1, BUSY = 1, dwell counter = 0.
  - Otherwise, EN = 1 → D = 1 << I, IDX = I, VALID = 1.
  - Otherwise → D = 0, VALID = 0. IDX holds its last value.
  - START has priority over EN when both are high.
- SWEEP:
  - Each cycle the dwell counter increments.
  - When the dwell counter reaches DWELL-1:
    - If IDX = OUT_W-1 → go to FIN.
    - Else → IDX = IDX+1, D = 1 << (IDX+1), dwell counter = 0.
  - EN, I and START are ignored.
  - ABORT = 1 → go to IDLE. D = 0, VALID = 0, BUSY = 0, no DONE pulse. ABORT takes priority over advance and finish.
- FIN: D = 0, VALID = 0, BUSY = 0, DONE = 1 for exactly this one cycle, then go to IDLE unconditionally. START in FIN is ignored.
- ABORT in IDLE or FIN has no effect.
- IDX never wraps past OUT_W-1. The dwell counter is ceil(log2(DWELL+1)) bits and never overflows.
- D is always either all-zero or exactly one-hot. VALID = 1 exactly when D != 0.

## Timing
- Direct mode latency is one cycle: I and EN sampled at edge t appear on D after edge t.
- Sweep: START sampled at edge t.
  - Line k is driven during edges t + k·DWELL through t + (k+1)·DWELL - 1.
  - DONE is high after edge t + OUT_W·DWELL.
  - IDLE is reached after edge t + OUT_W·DWELL + 1.
  - Total busy cycles = OUT_W·DWELL.
- Back-to-back sweeps: a new START is accepted at the first IDLE edge after FIN, giving a one-cycle gap with DONE in between.
- RST asserted mid-sweep clears all outputs immediately, without waiting for a clock edge. No DONE pulse is produced.

## Test plan
- Reset: assert RST with state in SWEEP at IDX = 7 → D = 0, BUSY = 0, DONE = 0 without a clock edge. Release RST → IDLE.
- Direct decode, ADDR_W = 5: EN = 1, I = 0..31, one per cycle → D = 32'h1 << I one cycle later, IDX = I, VALID = 1. EN = 0 → D = 0, VALID = 0.
- Full sweep, ADDR_W = 5, DWELL = 1: START pulse at edge 0 →
  - D = 32'h00000001 after edge 0.
  - D = 32'h80000000 after edge 31.
  - DONE = 1 and D = 0 after edge 32.
  - BUSY high for exactly 32 cycles.
- Dwell, ADDR_W = 3, DWELL = 3: START → each of 8'h01..8'h80 held 3 cycles. DONE after 24 cycles.
- Abort and priority:
  - ABORT at IDX = 10 → D = 0, BUSY = 0 next cycle, no DONE.
  - START = EN = 1 with I = 5 in IDLE → D = 1 (sweep starts), not 1 << 5.
- Ignored inputs: START held high throughout a sweep and during FIN → exactly one DONE pulse, then a new sweep starts from the following IDLE edge.

Source files
------------

// File: rtl/decoder_sweep_if.sv
// rtl/decoder_sweep_if.sv - control and decode-output bundle for decoder_sweep
interface decoder_sweep_if #(
  parameter int ADDR_W = 5
);
  localparam int OUT_W = 2 ** ADDR_W;

  logic              en;
  logic [ADDR_W-1:0] i;
  logic              start;
  logic              abort;
  logic [OUT_W-1:0]  d;
  logic [ADDR_W-1:0] idx;
  logic              valid;
  logic              busy;
  logic              done;

  modport master (
    output en, i, start, abort,
    input  d, idx, valid, busy, done
  );

  modport slave (
    input  en, i, start, abort,
    output d, idx, valid, busy, done
  );
endinterface

// File: rtl/decoder_sweep.sv
// rtl/decoder_sweep.sv - registered one-hot line decoder with autonomous dwell sweep
module decoder_sweep #(
  parameter int ADDR_W = 5,
  parameter int DWELL  = 1
) (
  input  logic            clk,
  input  logic            rst,
  decoder_sweep_if.slave  bus
);
  localparam int OUT_W = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(DWELL + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SWEEP = 2'd1;
  localparam logic [1:0] FIN   = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [OUT_W-1:0]  LINE0    = OUT_W'(1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  dwell_cnt;
  logic [OUT_W-1:0]  d_q;
  logic [ADDR_W-1:0] idx_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dwell_cnt <= '0;
      d_q       <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state     <= SWEEP;
            d_q       <= LINE0;
            idx_q     <= '0;
            valid_q   <= 1'b1;
            busy_q    <= 1'b1;
            dwell_cnt <= '0;
          end else if (bus.en) begin
            d_q     <= LINE0 << bus.i;
            idx_q   <= bus.i;
            valid_q <= 1'b1;
          end else begin
            // idx keeps the last decoded line so software can read it back
            d_q     <= '0;
            valid_q <= 1'b0;
          end
        end

        SWEEP: begin
          if (bus.abort) begin
            state     <= IDLE;
            d_q       <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            dwell_cnt <= '0;
          end else if (dwell_cnt == CNT_LAST) begin
            dwell_cnt <= '0;
            if (idx_q == LAST_IDX) begin
              state   <= FIN;
              d_q     <= '0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              // d is one-hot at idx, so shifting it tracks idx+1 without a decoder
              idx_q <= idx_q + ADDR_W'(1);
              d_q   <= d_q << 1;
            end
          end else begin
            dwell_cnt <= dwell_cnt + CNT_W'(1);
          end
        end

        FIN: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          dwell_cnt <= '0;
          d_q       <= '0;
          valid_q   <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.d     = d_q;
  assign bus.idx   = idx_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_decoder_sweep.sv
// tb/tb_decoder_sweep.sv - directed self-checking bench for decoder_sweep
module tb_decoder_sweep;
  logic clk;
  logic rst;

  int n_checks;
  int n_fail;

  decoder_sweep_if #(.ADDR_W(5)) if5 ();
  decoder_sweep_if #(.ADDR_W(3)) if3 ();

  decoder_sweep #(.ADDR_W(5), .DWELL(1)) u_dut5 (
    .clk (clk),
    .rst (rst),
    .bus (if5.slave)
  );

  decoder_sweep #(.ADDR_W(3), .DWELL(3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int busy_cycles;
    int done_pulses;
    logic [63:0] one;

    n_checks = 0;
    n_fail   = 0;
    one      = 64'd1;

    rst       = 1'b1;
    if5.en    = 1'b0;
    if5.i     = '0;
    if5.start = 1'b0;
    if5.abort = 1'b0;
    if3.en    = 1'b0;
    if3.i     = '0;
    if3.start = 1'b0;
    if3.abort = 1'b0;

    repeat (2) tick();
    check("reset_d",     64'(if5.d),     64'h0);
    check("reset_idx",   64'(if5.idx),   64'h0);
    check("reset_valid", 64'(if5.valid), 64'h0);
    check("reset_busy",  64'(if5.busy),  64'h0);
    check("reset_done",  64'(if5.done),  64'h0);
    rst = 1'b0;
    tick();
    check("idle_d", 64'(if5.d), 64'h0);

    // Direct decode of every index, one per cycle
    if5.en = 1'b1;
    for (int k = 0; k < 32; k++) begin
      if5.i = 5'(k);
      tick();
      check($sformatf("direct_d_%0d", k),   64'(if5.d),     one << k);
      check($sformatf("direct_idx_%0d", k), 64'(if5.idx),   64'(k));
      check($sformatf("direct_vld_%0d", k), 64'(if5.valid), 64'h1);
    end
    if5.en = 1'b0;
    tick();
    check("direct_off_d",     64'(if5.d),     64'h0);
    check("direct_off_valid", 64'(if5.valid), 64'h0);
    check("direct_off_idx",   64'(if5.idx),   64'd31);

    // Full sweep, DWELL=1
    busy_cycles = 0;
    if5.start = 1'b1;
    tick();
    if5.start = 1'b0;
    check("sweep_first_d",    64'(if5.d),    64'h1);
    check("sweep_first_idx",  64'(if5.idx),  64'h0);
    check("sweep_first_busy", 64'(if5.busy), 64'h1);
    if (if5.busy) busy_cycles++;
    for (int k = 1; k < 32; k++) begin
      tick();
      check($sformatf("sweep_d_%0d", k), 64'(if5.d), one << k);
      check($sformatf("sweep_done_%0d", k), 64'(if5.done), 64'h0);
      if (if5.busy) busy_cycles++;
    end
    check("sweep_last_d", 64'(if5.d), 64'h80000000);
    tick();
    if (if5.busy) busy_cycles++;
    check("sweep_fin_done",  64'(if5.done),  64'h1);
    check("sweep_fin_d",     64'(if5.d),     64'h0);
    check("sweep_fin_valid", 64'(if5.valid), 64'h0);
    check("sweep_fin_busy",  64'(if5.busy),  64'h0);
    check("sweep_busy_cycles", 64'(busy_cycles), 64'd32);
    tick();
    check("sweep_idle_done", 64'(if5.done), 64'h0);
    check("sweep_idle_busy", 64'(if5.busy), 64'h0);

    // Dwell of 3 cycles on the 3-bit decoder
    if3.start = 1'b1;
    tick();
    if3.start = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (c > 0) tick();
      check($sformatf("dwell_d_%0d", c),    64'(if3.d),    one << (c / 3));
      check($sformatf("dwell_busy_%0d", c), 64'(if3.busy), 64'h1);
      check($sformatf("dwell_done_%0d", c), 64'(if3.done), 64'h0);
    end
    tick();
    check("dwell_fin_done", 64'(if3.done), 64'h1);
    check("dwell_fin_d",    64'(if3.d),    64'h0);
    tick();
    check("dwell_idle_done", 64'(if3.done), 64'h0);

    // Abort at idx 10
    if5.start = 1'b1;
    tick();
    if5.start = 1'b0;
    repeat (10) tick();
    check("abort_pre_idx", 64'(if5.idx), 64'd10);
    check("abort_pre_d",   64'(if5.d),   one << 10);
    if5.abort = 1'b1;
    tick();
    if5.abort = 1'b0;
    check("abort_d",     64'(if5.d),     64'h0);
    check("abort_busy",  64'(if5.busy),  64'h0);
    check("abort_valid", 64'(if5.valid), 64'h0);
    check("abort_done",  64'(if5.done),  64'h0);
    done_pulses = 0;
    repeat (3) begin
      tick();
      if (if5.done) done_pulses++;
    end
    check("abort_no_done", 64'(done_pulses), 64'd0);

    // START beats EN in IDLE
    if5.start = 1'b1;
    if5.en    = 1'b1;
    if5.i     = 5'd5;
    tick();
    if5.start = 1'b0;
    if5.en    = 1'b0;
    check("prio_d",    64'(if5.d),    64'h1);
    check("prio_busy", 64'(if5.busy), 64'h1);
    if5.abort = 1'b1;
    tick();
    if5.abort = 1'b0;
    check("prio_abort_busy", 64'(if5.busy), 64'h0);

    // START held through a whole sweep and FIN
    done_pulses = 0;
    if5.start = 1'b1;
    if5.en    = 1'b1;
    if5.i     = 5'd5;
    tick();
    check("hold_first_d", 64'(if5.d), 64'h1);
    for (int k = 1; k < 32; k++) begin
      tick();
      check($sformatf("hold_d_%0d", k), 64'(if5.d), one << k);
      if (if5.done) done_pulses++;
    end
    tick();
    check("hold_fin_done", 64'(if5.done), 64'h1);
    if (if5.done) done_pulses++;
    tick();
    check("hold_gap_d",    64'(if5.d),    64'h0);
    check("hold_gap_busy", 64'(if5.busy), 64'h0);
    if (if5.done) done_pulses++;
    tick();
    check("hold_restart_d",    64'(if5.d),    64'h1);
    check("hold_restart_busy", 64'(if5.busy), 64'h1);
    if (if5.done) done_pulses++;
    check("hold_one_done", 64'(done_pulses), 64'd1);
    if5.start = 1'b0;
    if5.en    = 1'b0;
    if5.abort = 1'b1;
    tick();
    if5.abort = 1'b0;

    // Asynchronous reset mid-sweep at idx 7
    if5.start = 1'b1;
    tick();
    if5.start = 1'b0;
    repeat (7) tick();
    check("areset_pre_idx", 64'(if5.idx), 64'd7);
    #2;
    rst = 1'b1;
    #1;
    check("areset_d",     64'(if5.d),     64'h0);
    check("areset_busy",  64'(if5.busy),  64'h0);
    check("areset_done",  64'(if5.done),  64'h0);
    check("areset_valid", 64'(if5.valid), 64'h0);
    check("areset_idx",   64'(if5.idx),   64'h0);
    tick();
    rst = 1'b0;
    tick();
    check("areset_idle_d",    64'(if5.d),    64'h0);
    check("areset_idle_busy", 64'(if5.busy), 64'h0);
    check("areset_idle_done", 64'(if5.done), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
